// File: rtl/adpll_loop_ctrl.sv
// ADPLL loop controller: turns PFD up/down decisions into a saturating DCO
// control word. A binary-search acquisition phase (ACQ) narrows the step on
// every reversal or null, then a slow +/-1 tracking phase (TRACK) filters
// the PFD output and watches for settled phase or loss of lock.
module adpll_loop_ctrl #(
  parameter int CODE_W      = 8,
  parameter int CODE_MAX    = 127,
  parameter int CODE_INIT   = 64,
  parameter int STEP_INIT   = 32,
  parameter int STEP_RELOCK = 4,
  parameter int TRACK_N     = 4,
  parameter int UNLOCK_N    = 12,
  parameter int NULL_N      = 4
) (
  input  logic              phase_clk,
  input  logic              reset,
  input  logic              p_up,
  input  logic              p_down,
  input  logic              relock_req,
  output logic [CODE_W-1:0] dco_code,
  output logic              freq_lock,
  output logic              phase_lock,
  output logic              lock_lost,
  output logic [1:0]        state
);

  localparam int STEP_W = CODE_W + 1;
  localparam int RUN_W  = $clog2(UNLOCK_N + 1);
  localparam int TRK_W  = $clog2(TRACK_N + 1);
  localparam int NUL_W  = $clog2(NULL_N + 1);

  localparam logic [STEP_W-1:0] MAX_X       = STEP_W'(CODE_MAX);
  localparam logic [STEP_W-1:0] STEP_ONE    = STEP_W'(1);
  localparam logic [STEP_W-1:0] STEP_INIT_X = STEP_W'(STEP_INIT);
  localparam logic [STEP_W-1:0] STEP_REL_X  = STEP_W'(STEP_RELOCK);
  localparam logic [RUN_W-1:0]  RUN_MAX     = RUN_W'(UNLOCK_N);
  localparam logic [TRK_W-1:0]  TRK_MAX     = TRK_W'(TRACK_N);
  localparam logic [NUL_W-1:0]  NUL_MAX     = NUL_W'(NULL_N);

  typedef enum logic [1:0] {ST_ACQ = 2'd0, ST_TRACK = 2'd1} state_t;
  typedef enum logic [1:0] {DIR_NONE = 2'd0, DIR_UP = 2'd1, DIR_DN = 2'd2} dir_t;

  state_t              r_state, w_stateNxt;
  logic [CODE_W-1:0]   r_code, w_codeNxt;
  logic [STEP_W-1:0]   r_step, w_stepNxt;
  dir_t                r_lastDir, w_lastDirNxt;
  dir_t                r_runDir, w_runDirNxt;
  logic [RUN_W-1:0]    r_runCnt, w_runCntNxt;
  logic [TRK_W-1:0]    r_trkCnt, w_trkCntNxt;
  logic [NUL_W-1:0]    r_nullCnt, w_nullCntNxt;
  logic                r_freqLock, w_freqLockNxt;
  logic                r_phaseLock, w_phaseLockNxt;
  logic                r_lockLost, w_lockLostNxt;

  logic                w_up, w_dn, w_null;
  dir_t                w_dir;
  logic                w_reversal, w_stepOne, w_acqExit, w_sameRun;
  logic                w_unlock, w_trkHit;
  logic [RUN_W-1:0]    w_runNext;
  logic [TRK_W-1:0]    w_trkNext;
  logic [STEP_W-1:0]   w_amt, w_sum;
  logic [CODE_W-1:0]   w_codeUp, w_codeDn, w_codeStep;

  // Input decode: both or neither PFD outputs count as a null decision.
  assign w_up   = p_up & ~p_down;
  assign w_dn   = p_down & ~p_up;
  assign w_null = ~(w_up | w_dn);
  assign w_dir  = w_up ? DIR_UP : (w_dn ? DIR_DN : DIR_NONE);

  // Acquisition decisions.
  assign w_reversal = (w_up && r_lastDir == DIR_DN) || (w_dn && r_lastDir == DIR_UP);
  assign w_stepOne  = (r_step == STEP_ONE);
  assign w_acqExit  = (r_state == ST_ACQ) && (w_null || w_reversal) && w_stepOne;

  // Tracking run bookkeeping; the unlock check wins over a +/-1 correction.
  assign w_sameRun = !w_null && (w_dir == r_runDir);
  assign w_runNext = w_null ? '0 : (w_sameRun ? RUN_W'(r_runCnt + 1'b1) : RUN_W'(1));
  assign w_trkNext = w_sameRun ? TRK_W'(r_trkCnt + 1'b1) : TRK_W'(1);
  assign w_unlock  = (r_state == ST_TRACK) && !w_null && (w_runNext == RUN_MAX);
  assign w_trkHit  = (r_state == ST_TRACK) && !w_null && !w_unlock && (w_trkNext == TRK_MAX);

  // Code arithmetic is one bit wider than the code and clamps to [0, CODE_MAX].
  assign w_amt      = (r_state == ST_TRACK) ? STEP_ONE :
                      (w_reversal ? (w_stepOne ? STEP_ONE : (r_step >> 1)) : r_step);
  assign w_sum      = {1'b0, r_code} + w_amt;
  assign w_codeUp   = (w_sum > MAX_X) ? CODE_W'(CODE_MAX) : w_sum[CODE_W-1:0];
  assign w_codeDn   = (w_amt > {1'b0, r_code}) ? '0 : CODE_W'({1'b0, r_code} - w_amt);
  assign w_codeStep = w_up ? w_codeUp : w_codeDn;

  // State register.
  always_ff @(posedge phase_clk or posedge reset) begin
    if (reset) r_state <= ST_ACQ;
    else       r_state <= w_stateNxt;
  end

  // Next-state logic: relock beats everything, then acquisition exit or unlock.
  always_comb begin
    w_stateNxt = r_state;
    if (relock_req)                             w_stateNxt = ST_ACQ;
    else if (r_state == ST_ACQ && w_acqExit)    w_stateNxt = ST_TRACK;
    else if (r_state == ST_TRACK && w_unlock)   w_stateNxt = ST_ACQ;
  end

  // Datapath next values: code, step, direction memory, counters and flags.
  always_comb begin
    w_codeNxt      = r_code;
    w_stepNxt      = r_step;
    w_lastDirNxt   = r_lastDir;
    w_runDirNxt    = r_runDir;
    w_runCntNxt    = r_runCnt;
    w_trkCntNxt    = r_trkCnt;
    w_nullCntNxt   = r_nullCnt;
    w_freqLockNxt  = r_freqLock;
    w_phaseLockNxt = r_phaseLock;
    w_lockLostNxt  = 1'b0;
    if (relock_req) begin
      w_stepNxt      = STEP_INIT_X;
      w_lastDirNxt   = DIR_NONE;
      w_runDirNxt    = DIR_NONE;
      w_runCntNxt    = '0;
      w_trkCntNxt    = '0;
      w_nullCntNxt   = '0;
      w_freqLockNxt  = 1'b0;
      w_phaseLockNxt = 1'b0;
    end else if (r_state == ST_ACQ) begin
      if (!w_null) begin
        w_codeNxt    = w_codeStep;
        w_lastDirNxt = w_dir;
        if (w_reversal && !w_stepOne) w_stepNxt = r_step >> 1;
      end else if (!w_stepOne) begin
        w_stepNxt = r_step >> 1;
      end
      if (w_acqExit) begin
        w_freqLockNxt  = 1'b1;
        w_phaseLockNxt = 1'b0;
        w_runDirNxt    = DIR_NONE;
        w_runCntNxt    = '0;
        w_trkCntNxt    = '0;
        w_nullCntNxt   = '0;
      end
    end else begin
      if (w_null) begin
        w_runDirNxt  = DIR_NONE;
        w_runCntNxt  = '0;
        w_trkCntNxt  = '0;
        w_nullCntNxt = (r_nullCnt == NUL_MAX) ? r_nullCnt : NUL_W'(r_nullCnt + 1'b1);
        if (w_nullCntNxt == NUL_MAX) w_phaseLockNxt = 1'b1;
      end else begin
        w_nullCntNxt   = '0;
        w_phaseLockNxt = 1'b0;
        if (w_unlock) begin
          w_stepNxt     = STEP_REL_X;
          w_lastDirNxt  = DIR_NONE;
          w_runDirNxt   = DIR_NONE;
          w_runCntNxt   = '0;
          w_trkCntNxt   = '0;
          w_freqLockNxt = 1'b0;
          w_lockLostNxt = 1'b1;
        end else begin
          w_runDirNxt = w_dir;
          w_runCntNxt = w_runNext;
          w_trkCntNxt = w_trkHit ? '0 : w_trkNext;
          if (w_trkHit) w_codeNxt = w_codeStep;
        end
      end
    end
  end

  // Datapath registers with asynchronous reset to the power-up operating point.
  always_ff @(posedge phase_clk or posedge reset) begin
    if (reset) begin
      r_code      <= CODE_W'(CODE_INIT);
      r_step      <= STEP_INIT_X;
      r_lastDir   <= DIR_NONE;
      r_runDir    <= DIR_NONE;
      r_runCnt    <= '0;
      r_trkCnt    <= '0;
      r_nullCnt   <= '0;
      r_freqLock  <= 1'b0;
      r_phaseLock <= 1'b0;
      r_lockLost  <= 1'b0;
    end else begin
      r_code      <= w_codeNxt;
      r_step      <= w_stepNxt;
      r_lastDir   <= w_lastDirNxt;
      r_runDir    <= w_runDirNxt;
      r_runCnt    <= w_runCntNxt;
      r_trkCnt    <= w_trkCntNxt;
      r_nullCnt   <= w_nullCntNxt;
      r_freqLock  <= w_freqLockNxt;
      r_phaseLock <= w_phaseLockNxt;
      r_lockLost  <= w_lockLostNxt;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    dco_code   = r_code;
    freq_lock  = r_freqLock;
    phase_lock = r_phaseLock;
    lock_lost  = r_lockLost;
    state      = r_state;
  end

endmodule

// File: tb/tb_adpll_loop_ctrl.sv
// Self-checking bench for adpll_loop_ctrl: a table of stimulus/expected
// records feeds a scoreboard queue, plus a hand-written async-reset sequence.
module tb_adpll_loop_ctrl;

  typedef struct {
    bit rst;
    bit up;
    bit dn;
    bit rl;
    int code;
    int st;
    bit fl;
    bit pl;
    bit ll;
  } vec_t;

  typedef struct {
    int code;
    int st;
    bit fl;
    bit pl;
    bit ll;
  } exp_t;

  logic       phaseClk = 1'b0;
  logic       reset;
  logic       pUp, pDown, relockReq;
  logic [7:0] dcoCode;
  logic       freqLock, phaseLock, lockLost;
  logic [1:0] state;

  int   total = 0;
  int   bad   = 0;
  vec_t vecs[$];
  exp_t sbQ[$];

  adpll_loop_ctrl dut (
    .phase_clk (phaseClk),
    .reset     (reset),
    .p_up      (pUp),
    .p_down    (pDown),
    .relock_req(relockReq),
    .dco_code  (dcoCode),
    .freq_lock (freqLock),
    .phase_lock(phaseLock),
    .lock_lost (lockLost),
    .state     (state)
  );

  // Free-running loop clock.
  always #5 phaseClk = ~phaseClk;

  // Watchdog so the run can never hang.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic addVec(input bit rst, input bit up, input bit dn, input bit rl,
                        input int code, input int st, input bit fl, input bit pl, input bit ll);
    vec_t v;
    v = '{rst:rst, up:up, dn:dn, rl:rl, code:code, st:st, fl:fl, pl:pl, ll:ll};
    vecs.push_back(v);
  endtask

  // Reset, then six null edges: step walks 16,8,4,2,1 and the sixth enters TRACK.
  task automatic addNullEntry();
    addVec(1, 0, 0, 0, 64, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) addVec(0, 0, 0, 0, 64, 0, 0, 0, 0);
    addVec(0, 0, 0, 0, 64, 1, 1, 0, 0);
  endtask

  task automatic cmp(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    @(negedge phaseClk);
    if (v.rst) begin
      reset = 1'b1;
      #2;
      reset = 1'b0;
    end
    pUp       = v.up;
    pDown     = v.dn;
    relockReq = v.rl;
    e = '{code:v.code, st:v.st, fl:v.fl, pl:v.pl, ll:v.ll};
    sbQ.push_back(e);
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    @(posedge phaseClk);
    #1;
    if (sbQ.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL %s scoreboard: got empty expected entry", tag);
    end else begin
      e = sbQ.pop_front();
      cmp({tag, " code"},  int'(dcoCode),   e.code);
      cmp({tag, " state"}, int'(state),     e.st);
      cmp({tag, " freq"},  int'(freqLock),  int'(e.fl));
      cmp({tag, " phase"}, int'(phaseLock), int'(e.pl));
      cmp({tag, " lost"},  int'(lockLost),  int'(e.ll));
    end
  endtask

  initial begin
    reset     = 1'b1;
    pUp       = 1'b0;
    pDown     = 1'b0;
    relockReq = 1'b0;
    #1;
    cmp("por code",  int'(dcoCode),   64);
    cmp("por state", int'(state),     0);
    cmp("por freq",  int'(freqLock),  0);
    cmp("por phase", int'(phaseLock), 0);
    cmp("por lost",  int'(lockLost),  0);
    @(negedge phaseClk);
    reset = 1'b0;

    // Null walk into TRACK, phase settle, both-high nulls, run restart, relock.
    addNullEntry();
    for (int k = 0; k < 3; k++) addVec(0, 0, 0, 0, 64, 1, 1, 0, 0);
    addVec(0, 0, 0, 0, 64, 1, 1, 1, 0);
    for (int k = 0; k < 3; k++) addVec(0, 1, 1, 0, 64, 1, 1, 1, 0);
    for (int k = 0; k < 3; k++) addVec(0, 1, 0, 0, 64, 1, 1, 0, 0);
    for (int k = 0; k < 3; k++) addVec(0, 0, 1, 0, 64, 1, 1, 0, 0);
    addVec(0, 0, 1, 0, 63, 1, 1, 0, 0);
    addVec(0, 0, 0, 1, 63, 0, 0, 0, 0);
    addVec(0, 1, 0, 0, 95, 0, 0, 0, 0);

    // Saturation at the top, reversals down to step 1, TRACK entry by reversal,
    // then a long DN run to loss of lock and an UP with the relock step.
    addVec(1, 1, 0, 0, 96, 0, 0, 0, 0);
    addVec(0, 1, 0, 0, 127, 0, 0, 0, 0);
    addVec(0, 1, 0, 0, 127, 0, 0, 0, 0);
    addVec(0, 0, 1, 0, 111, 0, 0, 0, 0);
    addVec(0, 0, 1, 0, 95, 0, 0, 0, 0);
    addVec(0, 1, 0, 0, 103, 0, 0, 0, 0);
    addVec(0, 0, 0, 0, 103, 0, 0, 0, 0);
    addVec(0, 0, 1, 0, 101, 0, 0, 0, 0);
    addVec(0, 1, 0, 0, 102, 0, 0, 0, 0);
    addVec(0, 0, 1, 0, 101, 1, 1, 0, 0);
    for (int k = 1; k <= 11; k++)
      addVec(0, 0, 1, 0, (k < 4) ? 101 : ((k < 8) ? 100 : 99), 1, 1, 0, 0);
    addVec(0, 0, 1, 0, 99, 0, 0, 0, 1);
    addVec(0, 1, 0, 0, 103, 0, 0, 0, 0);

    // TRACK at 64 with twelve UPs: 65 at 4, 66 at 8, unlock at 12.
    addNullEntry();
    for (int k = 1; k <= 11; k++)
      addVec(0, 1, 0, 0, (k < 4) ? 64 : ((k < 8) ? 65 : 66), 1, 1, 0, 0);
    addVec(0, 1, 0, 0, 66, 0, 0, 0, 1);
    addVec(0, 0, 0, 0, 66, 0, 0, 0, 0);

    // Saturation at zero, then a reversal upward.
    addVec(1, 0, 1, 0, 32, 0, 0, 0, 0);
    addVec(0, 0, 1, 0, 0, 0, 0, 0, 0);
    addVec(0, 0, 1, 0, 0, 0, 0, 0, 0);
    addVec(0, 1, 0, 0, 16, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("v%0d", i));
    end

    // Asynchronous reset between edges, then a DN that must act as a fresh first step.
    @(negedge phaseClk);
    pUp   = 1'b0;
    pDown = 1'b0;
    @(posedge phaseClk);
    #2;
    reset = 1'b1;
    #1;
    cmp("async code",  int'(dcoCode),   64);
    cmp("async state", int'(state),     0);
    cmp("async freq",  int'(freqLock),  0);
    cmp("async phase", int'(phaseLock), 0);
    cmp("async lost",  int'(lockLost),  0);
    @(negedge phaseClk);
    reset = 1'b0;
    pDown = 1'b1;
    @(posedge phaseClk);
    #1;
    cmp("fresh code",  int'(dcoCode), 32);
    cmp("fresh state", int'(state),   0);

    if (sbQ.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL scoreboard leftover: got %0d expected 0", sbQ.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
